spi_xfer_sequencer: RTL and testbench

//  Sequences multi-byte SPI transactions on a single SPI_Master byte interface.
//  A requester posts a start command with a byte count, then streams TX bytes in and receives RX bytes out.
//  The block owns chip-select timing (setup, hold, inter-transaction gap) and paces bytes against master readiness.

---
 rtl/spi_xfer_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI transaction sequencer in front of a byte-wide SPI_Master.
// Owns chip-select setup/hold/gap timing and paces TX bytes against master readiness.
module spi_xfer_sequencer #(
    parameter int LEN_W         = 8,
    parameter int CS_SETUP_CLKS = 2,
    parameter int CS_HOLD_CLKS  = 2,
    parameter int CS_IDLE_CLKS  = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic [LEN_W-1:0] i_Len,
    output logic             o_Busy,
    output logic             o_Done,
    input  logic [7:0]       i_TX_Byte,
    input  logic             i_TX_Valid,
    output logic             o_TX_Ready,
    output logic [7:0]       o_RX_Byte,
    output logic             o_RX_DV,
    output logic [7:0]       o_M_TX_Byte,
    output logic             o_M_TX_DV,
    input  logic             i_M_TX_Ready,
    input  logic             i_M_RX_DV,
    input  logic [7:0]       i_M_RX_Byte,
    output logic             o_SPI_CS_n
);

    localparam int TMR_MAX_SH = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int TMR_MAX    = (TMR_MAX_SH > CS_IDLE_CLKS) ? TMR_MAX_SH : CS_IDLE_CLKS;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP_CLKS - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD_CLKS - 1);
    localparam logic [TMR_W-1:0] IDLE_LAST  = TMR_W'(CS_IDLE_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             cs_n_q, cs_n_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [7:0]       m_tx_byte_q, m_tx_byte_nxt;
    logic             m_tx_dv_q, m_tx_dv_nxt;
    logic [7:0]       rx_byte_q, rx_byte_nxt;
    logic             rx_dv_q, rx_dv_nxt;
    logic             tx_ready;

    // Remaining-byte count never wraps below zero.
    function automatic logic [LEN_W-1:0] dec_floor0(input logic [LEN_W-1:0] v);
        if (v == '0) begin
            return '0;
        end
        return v - LEN_W'(1);
    endfunction

    assign tx_ready = (state == ST_LOAD) && i_M_TX_Ready;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            tmr         <= '0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            m_tx_byte_q <= '0;
            m_tx_dv_q   <= 1'b0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            tmr         <= tmr_nxt;
            cs_n_q      <= cs_n_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            m_tx_byte_q <= m_tx_byte_nxt;
            m_tx_dv_q   <= m_tx_dv_nxt;
            rx_byte_q   <= rx_byte_nxt;
            rx_dv_q     <= rx_dv_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tmr_nxt       = tmr;
        cs_n_nxt      = cs_n_q;
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;
        m_tx_byte_nxt = m_tx_byte_q;
        m_tx_dv_nxt   = 1'b0;
        rx_byte_nxt   = rx_byte_q;
        rx_dv_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_Start && (i_Len != '0)) begin
                    cnt_nxt   = i_Len;
                    tmr_nxt   = '0;
                    cs_n_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr == SETUP_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = ST_LOAD;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            ST_LOAD: begin
                if (i_TX_Valid && tx_ready) begin
                    m_tx_byte_nxt = i_TX_Byte;
                    m_tx_dv_nxt   = 1'b1;
                    state_nxt     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_M_RX_DV) begin
                    rx_byte_nxt = i_M_RX_Byte;
                    rx_dv_nxt   = 1'b1;
                    cnt_nxt     = dec_floor0(cnt);
                    if (dec_floor0(cnt) == '0) begin
                        tmr_nxt   = '0;
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                // CS_n release and the done pulse land on the same edge.
                if (tmr == HOLD_LAST) begin
                    tmr_nxt   = '0;
                    cs_n_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_GAP;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (tmr == IDLE_LAST) begin
                    tmr_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cs_n_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_TX_Ready  = tx_ready;
    assign o_RX_Byte   = rx_byte_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_M_TX_Byte = m_tx_byte_q;
    assign o_M_TX_DV   = m_tx_dv_q;
    assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer with a behavioural SPI_Master and loopback slave.
module tb_spi_xfer_sequencer;

    logic       clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Start = 1'b0;
    logic [7:0] i_Len = 8'd0;
    logic       o_Busy;
    logic       o_Done;
    logic [7:0] i_TX_Byte = 8'd0;
    logic       i_TX_Valid = 1'b0;
    logic       o_TX_Ready;
    logic [7:0] o_RX_Byte;
    logic       o_RX_DV;
    logic [7:0] o_M_TX_Byte;
    logic       o_M_TX_DV;
    logic       i_M_TX_Ready = 1'b1;
    logic       i_M_RX_DV = 1'b0;
    logic [7:0] i_M_RX_Byte = 8'd0;
    logic       o_SPI_CS_n;

    spi_xfer_sequencer dut (
        .i_Clk       (clk),
        .i_Rst       (i_Rst),
        .i_Start     (i_Start),
        .i_Len       (i_Len),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .i_TX_Byte   (i_TX_Byte),
        .i_TX_Valid  (i_TX_Valid),
        .o_TX_Ready  (o_TX_Ready),
        .o_RX_Byte   (o_RX_Byte),
        .o_RX_DV     (o_RX_DV),
        .o_M_TX_Byte (o_M_TX_Byte),
        .o_M_TX_DV   (o_M_TX_DV),
        .i_M_TX_Ready(i_M_TX_Ready),
        .i_M_RX_DV   (i_M_RX_DV),
        .i_M_RX_Byte (i_M_RX_Byte),
        .o_SPI_CS_n  (o_SPI_CS_n)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_mtx[$];
    logic [7:0] tx_v[8];
    logic [7:0] ex_v[8];

    int  done_cnt = 0, rx_cnt = 0, mdv_cnt = 0, cs_fall_cnt = 0;
    int  cs_fall_cyc = 0, cs_rise_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
    int  first_mdv_cyc = 0, last_rx_cyc = 0;
    bit  want_first = 1'b0;
    logic prev_cs = 1'b1;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    always @(posedge clk) cyc++;

    // SPI_Master model: 8-cycle byte time; slave echoes previous byte, preloaded 5A while deselected.
    logic [7:0] slave_reg = 8'h5A;
    logic [7:0] m_last = 8'h00;
    int         m_cnt = 0;
    always @(negedge clk) begin
        i_M_RX_DV = 1'b0;
        if (o_SPI_CS_n) slave_reg = 8'h5A;
        if (i_Rst) begin
            m_cnt = 0;
            i_M_TX_Ready = 1'b1;
        end else if (o_M_TX_DV) begin
            m_last = o_M_TX_Byte;
            m_cnt = 8;
            i_M_TX_Ready = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                i_M_RX_DV = 1'b1;
                i_M_RX_Byte = slave_reg;
                slave_reg = m_last;
                i_M_TX_Ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboards and records edge timing.
    always @(negedge clk) begin
        if (o_SPI_CS_n !== prev_cs) begin
            if (!o_SPI_CS_n) begin
                cs_fall_cnt++;
                cs_fall_cyc = cyc;
                want_first = 1'b1;
            end else begin
                cs_rise_cyc = cyc;
            end
        end
        if (o_Busy && !prev_busy) busy_rise_cyc = cyc;
        if (!o_Busy && prev_busy) busy_fall_cyc = cyc;
        if (o_M_TX_DV) begin
            mdv_cnt++;
            if (want_first) begin
                first_mdv_cyc = cyc;
                want_first = 1'b0;
            end
            if (exp_mtx.size() == 0) fail_now("m_tx_unexpected");
            else check("m_tx_byte", 32'(o_M_TX_Byte), 32'(exp_mtx.pop_front()));
        end
        if (o_RX_DV) begin
            rx_cnt++;
            last_rx_cyc = cyc;
            if (exp_rx.size() == 0) fail_now("rx_unexpected");
            else check("rx_byte", 32'(o_RX_Byte), 32'(exp_rx.pop_front()));
        end
        if (o_Done) begin
            done_cnt++;
            check("done_with_cs_rise", 32'({prev_cs, o_SPI_CS_n}), 32'(2'b01));
        end
        prev_cs = o_SPI_CS_n;
        prev_busy = o_Busy;
    end

    task automatic run_txn(input string tag, input int len, input int stall_idx,
                           input int abort_after, input bit gap_start);
        int  done0 = done_cnt;
        int  rx0 = rx_cnt;
        int  mdv0 = mdv_cnt;
        int  fall0 = cs_fall_cnt;
        bit  ok;
        int  bad;
        for (int i = 0; i < len; i++) begin
            exp_rx.push_back(ex_v[i]);
            exp_mtx.push_back(tx_v[i]);
        end
        @(negedge clk); #1;
        i_Start = 1'b1;
        i_Len = 8'(len);
        i_TX_Byte = tx_v[0];
        i_TX_Valid = 1'b1;
        @(negedge clk); #1;
        i_Start = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == stall_idx) begin
                ok = 1'b0;
                for (int k = 0; k < 100 && !ok; k++) begin
                    @(posedge clk); #1;
                    if (o_TX_Ready) ok = 1'b1;
                end
                if (!ok) fail_now({tag, "_stall_ready_timeout"});
                bad = 0;
                for (int k = 0; k < 50; k++) begin
                    @(posedge clk); #1;
                    if (!o_TX_Ready || o_SPI_CS_n) bad++;
                end
                check({tag, "_stall_bad_cycles"}, 32'(bad), 32'd0);
            end
            i_TX_Byte = tx_v[i];
            i_TX_Valid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(posedge clk); #1;
                if (o_M_TX_DV) ok = 1'b1;
            end
            if (!ok) begin
                fail_now({tag, "_accept_timeout"});
                i_TX_Valid = 1'b0;
                return;
            end
            if (i + 1 == stall_idx) i_TX_Valid = 1'b0;
            if (i + 1 == abort_after) begin
                i_Rst = 1'b1;
                @(posedge clk); #1;
                check({tag, "_rst_cs_n"}, 32'(o_SPI_CS_n), 32'd1);
                check({tag, "_rst_busy"}, 32'(o_Busy), 32'd0);
                check({tag, "_rst_done"}, 32'(o_Done), 32'd0);
                check({tag, "_rst_m_tx_dv"}, 32'(o_M_TX_DV), 32'd0);
                i_Rst = 1'b0;
                i_TX_Valid = 1'b0;
                exp_rx.delete();
                exp_mtx.delete();
                repeat (20) @(negedge clk);
                #1;
                check({tag, "_rst_no_done"}, 32'(done_cnt - done0), 32'd0);
                check({tag, "_rst_cs_stays_high"}, 32'(o_SPI_CS_n), 32'd1);
                return;
            end
        end
        i_TX_Valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk); #1;
            if (o_Done) ok = 1'b1;
        end
        if (!ok) fail_now({tag, "_done_timeout"});
        if (gap_start) begin
            i_Start = 1'b1;
            i_Len = 8'd3;
            @(negedge clk); #1;
            i_Start = 1'b0;
        end
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk); #1;
            if (!o_Busy) ok = 1'b1;
        end
        if (!ok) fail_now({tag, "_busy_timeout"});
        check({tag, "_done_count"}, 32'(done_cnt - done0), 32'd1);
        check({tag, "_rx_count"}, 32'(rx_cnt - rx0), 32'(len));
        check({tag, "_m_tx_count"}, 32'(mdv_cnt - mdv0), 32'(len));
        check({tag, "_cs_fall_count"}, 32'(cs_fall_cnt - fall0), 32'd1);
        check({tag, "_rx_left"}, 32'(exp_rx.size()), 32'd0);
        check({tag, "_busy_with_cs"}, 32'(busy_rise_cyc - cs_fall_cyc), 32'd0);
        check({tag, "_cs_setup"}, 32'(first_mdv_cyc - cs_fall_cyc), 32'd3);
        check({tag, "_cs_hold"}, 32'(cs_rise_cyc - last_rx_cyc), 32'd2);
        check({tag, "_cs_gap"}, 32'(busy_fall_cyc - cs_rise_cyc), 32'd4);
        if (gap_start) begin
            repeat (10) @(negedge clk);
            #1;
            check({tag, "_gap_start_busy"}, 32'(o_Busy), 32'd0);
            check({tag, "_gap_start_cs"}, 32'(cs_fall_cnt - fall0), 32'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall0;
        int done0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_cs_n", 32'(o_SPI_CS_n), 32'd1);
        check("reset_busy", 32'(o_Busy), 32'd0);
        check("reset_done", 32'(o_Done), 32'd0);
        check("reset_tx_ready", 32'(o_TX_Ready), 32'd0);
        check("reset_rx_dv", 32'(o_RX_DV), 32'd0);
        check("reset_m_tx_dv", 32'(o_M_TX_DV), 32'd0);
        check("reset_m_tx_byte", 32'(o_M_TX_Byte), 32'd0);
        check("reset_rx_byte", 32'(o_RX_Byte), 32'd0);
        i_Rst = 1'b0;

        tx_v = '{8'hC1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex_v = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("t1", 1, -1, 0, 1'b0);

        tx_v = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h00, 8'h00};
        ex_v = '{8'h5A, 8'h00, 8'h01, 8'h80, 8'hFF, 8'h55, 8'h00, 8'h00};
        run_txn("t2", 6, -1, 0, 1'b0);

        tx_v = '{8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex_v = '{8'h5A, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("t3", 3, 1, 0, 1'b0);

        fall0 = cs_fall_cnt;
        done0 = done_cnt;
        @(negedge clk); #1;
        i_Start = 1'b1;
        i_Len = 8'd0;
        @(negedge clk); #1;
        i_Start = 1'b0;
        check("t4_len0_busy_now", 32'(o_Busy), 32'd0);
        repeat (8) @(negedge clk);
        #1;
        check("t4_len0_busy", 32'(o_Busy), 32'd0);
        check("t4_len0_cs_edges", 32'(cs_fall_cnt - fall0), 32'd0);
        check("t4_len0_done", 32'(done_cnt - done0), 32'd0);

        tx_v = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex_v = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("t4gap", 1, -1, 0, 1'b1);

        tx_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        ex_v = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("t5abort", 4, -1, 2, 1'b0);

        tx_v = '{8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ex_v = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_txn("t5new", 1, -1, 0, 1'b0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
